// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : Receive half of the board UART link. Recovers start/data/stop
//            frames (LSB-first data, one stop bit) from the serial line using
//            the shared oversampling baud_tick, presents each good word with
//            a one-cycle rx_valid strobe and flags bad stop bits with a
//            one-cycle frame_err strobe.
// Ports    : clk        system clock, all logic on posedge
//            reset      asynchronous active-low reset
//            baud_tick  one-clk strobe at OVERSAMPLE x baud rate
//            rx_in      raw asynchronous serial line, idles high
//            rx_data    last good received word, held until the next one
//            rx_valid   one-clk pulse when rx_data is updated
//            frame_err  one-clk pulse when the stop bit samples low
//            rx_busy    high while a frame is in progress
// Options  : define UART_RX_MAJORITY_EN to make every start/data/stop
//            decision a 2-of-3 majority over the last three baud_ticks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int FRAME_BITS = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  rx_in,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(FRAME_BITS);

  localparam logic [SW-1:0] MID_SAMPLE  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] ONE_SAMPLE  = SW'(1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] ONE_BIT     = BW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                state;
  logic [SW-1:0]         sample_index;
  logic [BW-1:0]         bit_index;
  logic [FRAME_BITS-1:0] shift_reg;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer; both stages reset to the idle (high) line level so
  // that leaving reset never looks like a start edge.
  // --------------------------------------------------------------------------
  logic sync_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync_meta <= rx_in;
      rx_s      <= sync_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Decision bit used at the start check, each data bit and the stop bit.
  // --------------------------------------------------------------------------
  logic rx_bit;

`ifdef UART_RX_MAJORITY_EN
  // History of rx_s on the two previous baud_ticks; together with the current
  // rx_s this gives the three ticks ending at the decision point.
  logic [1:0] tick_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_hist <= 2'b11;
    end else if (baud_tick) begin
      tick_hist <= {tick_hist[0], rx_s};
    end
  end

  assign rx_bit = (tick_hist[1] & tick_hist[0]) |
                  (tick_hist[1] & rx_s)         |
                  (tick_hist[0] & rx_s);
`else
  assign rx_bit = rx_s;
`endif

  // --------------------------------------------------------------------------
  // Receive state machine. Nothing moves without baud_tick; the strobes are
  // cleared every cycle so they last exactly one clk.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sample_index <= '0;
      bit_index    <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (baud_tick) begin
        case (state)
          IDLE: begin
            sample_index <= '0;
            bit_index    <= '0;
            // The tick that sees the falling edge counts as sample 0 of the
            // start bit, so the start check lands on the start-bit centre.
            if (!rx_s) begin
              state        <= START;
              sample_index <= ONE_SAMPLE;
              rx_busy      <= 1'b1;
            end
          end

          START: begin
            if (sample_index == MID_SAMPLE) begin
              sample_index <= '0;
              if (rx_bit) begin
                // Line already back high at the centre: a glitch, not a frame.
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                // From here on a full bit period lands on each bit centre.
                state     <= DATA;
                bit_index <= '0;
              end
            end else begin
              sample_index <= sample_index + ONE_SAMPLE;
            end
          end

          DATA: begin
            if (sample_index == LAST_SAMPLE) begin
              sample_index <= '0;
              // Right shift: the first (LSB) data bit ends up at bit 0.
              shift_reg <= {rx_bit, shift_reg[FRAME_BITS-1:1]};
              if (bit_index == LAST_BIT) begin
                state     <= STOP;
                bit_index <= '0;
              end else begin
                bit_index <= bit_index + ONE_BIT;
              end
            end else begin
              sample_index <= sample_index + ONE_SAMPLE;
            end
          end

          STOP: begin
            if (sample_index == LAST_SAMPLE) begin
              sample_index <= '0;
              rx_busy      <= 1'b0;
              if (rx_bit) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                state    <= IDLE;
              end else begin
                // Bad stop bit: keep the old word and wait for the line to
                // recover so a held-low break does not spawn more frames.
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end else begin
              sample_index <= sample_index + ONE_SAMPLE;
            end
          end

          WAIT_IDLE: begin
            sample_index <= '0;
            bit_index    <= '0;
            if (rx_s) begin
              state <= IDLE;
            end
          end

          default: begin
            state        <= IDLE;
            sample_index <= '0;
            bit_index    <= '0;
            rx_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the board UART link. Recovers FRAME_BITS-wide 8N1-style frames (one start bit, LSB-first data, one stop bit) from the serial line.
- Uses the same shared oversampling baud_tick that drives the transmit side.
- Presents each received word with a one-cycle valid strobe to the command/decode logic.
- Flags malformed frames (bad stop bit) so upstream logic can discard them.

Parameters:
- FRAME_BITS, 8, data bits per frame, LSB first; legal range 5..9.
- OVERSAMPLE, 16, baud_tick pulses per bit period; even, at least 8.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset; logic 0 clears all state immediately.
- baud_tick  input  1  single-clk strobe at OVERSAMPLE x baud rate.
- rx_in  input  1  raw asynchronous serial line; idles high.
- rx_data  output  FRAME_BITS  last good received word; held until the next good frame.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- frame_err  output  1  one-clk pulse when the stop bit samples low.
- rx_busy  output  1  high while a frame is in progress (state not IDLE/WAIT_IDLE).

Behaviour:
- Input sync: rx_in passes through a 2-flop synchronizer (rx_s), both flops reset to 1. All decisions use rx_s only.
- Counters: sample_index is $clog2(OVERSAMPLE) bits; bit_index is $clog2(FRAME_BITS) bits. Both advance only on baud_tick, and wrap or clear explicitly, never overflow.
- Mid-bit sample point: sample_index == OVERSAMPLE/2-1 within the bit.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, rx_busy=0, state=IDLE, counters=0, shift register=0.

States:
- IDLE: counters held at 0. On baud_tick with rx_s==0, go to START with sample_index=1.
- START: sample_index increments on baud_tick.
  - At the mid-bit sample point, if rx_s==1: false start; go to IDLE, no strobes.
  - Otherwise go to DATA with sample_index=0 and bit_index=0.
  - Result: mid-bit alignment for all later samples.
- DATA: sample_index counts 0..OVERSAMPLE-1 and wraps.
  - At sample_index==OVERSAMPLE-1 on baud_tick, shift rx_s in at the MSB of the shift register (right shift), so the first data bit ends at bit 0.
  - After the FRAME_BITS-th sample, go to STOP with sample_index=0.
- STOP: on baud_tick with sample_index==OVERSAMPLE-1:
  - if rx_s==1: rx_data<=shift register, rx_valid=1 for that one following cycle; go to IDLE.
  - else: frame_err=1 for one cycle, rx_data unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stays until a baud_tick with rx_s==1, then IDLE. This prevents a break (line held low) from retriggering frames.

Timing:
- Latency: rx_valid/frame_err asserts on the clk edge after the stop-bit centre baud_tick, i.e. 2 sync cycles plus (1.5 + FRAME_BITS) bit periods after the start edge, quantized to baud_tick.
- baud_tick low: no counter or state change in any state.
- No buffering: a new good frame overwrites rx_data. The consumer must take the word on the rx_valid cycle.
- rx_valid and frame_err are never high together.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded with no strobe.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each data and stop decision is the 2-of-3 majority of rx_s taken on the three baud_ticks ending at the decision point (sample_index OVERSAMPLE-3..OVERSAMPLE-1 in DATA/STOP, centred at mid-bit). The START false-start check uses the majority of mid-2..mid. Rejects single-tick glitches.
- Undefined: single sample as above. Latency identical in both builds.

Test Plan (FRAME_BITS=8, OVERSAMPLE=16, baud_tick every 4th clk):
- Drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one rx_valid pulse, rx_data=0xA5, frame_err stays 0, rx_busy falls after stop.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses; rx_data=0x00, then 0xFF.
- Frame 0x3C with stop bit driven 0, then line held low 40 bit times -> one frame_err pulse, no rx_valid, rx_data keeps prior value, no further strobes until line returns high. A following 0x55 frame is received correctly.
- Low glitch of 4 baud_ticks on idle line -> false start: no strobes, state back to IDLE, rx_busy high no longer than 8 ticks.
- Assert reset (0) during data bit 4 of 0x81, release, send 0x7E -> no strobe for the aborted frame, rx_data=0x7E after the second frame.
- With UART_RX_MAJORITY_EN: inject a 1-tick inverted glitch at the centre of each data bit of 0x96 -> rx_data=0x96. Without the macro, the same stimulus -> rx_data=0x69.
